// File: rtl/md_unit.sv
// HI/LO multiply/divide responder for the E stage: accepts mult/div commands,
// holds busy for a fixed latency, then commits the latched result to HI/LO.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  HLOp,
  input  logic        en,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] HLOut
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFLO  = 4'd5;
  localparam logic [3:0] OP_MFHI  = 4'd6;
  localparam logic [3:0] OP_MTLO  = 4'd7;
  localparam logic [3:0] OP_MTHI  = 4'd8;

  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic               r_res_wr;
  logic [31:0]        r_res_hi;
  logic [31:0]        r_res_lo;

  logic [3:0]         w_op;
  logic               w_is_md;
  logic [CW-1:0]      w_load;
  logic signed [63:0] w_prod_s;
  logic [63:0]        w_prod_u;
  logic [31:0]        w_divu_b;
  logic [31:0]        w_quo_u;
  logic [31:0]        w_rem_u;
  logic signed [31:0] w_sa;
  logic signed [31:0] w_sdiv_b;
  logic signed [31:0] w_quo_s;
  logic signed [31:0] w_rem_s;
  logic               w_ovf;
  logic [31:0]        w_res_hi;
  logic [31:0]        w_res_lo;
  logic               w_res_wr;

  assign w_op    = en ? HLOp : OP_NONE;
  assign w_is_md = (w_op == OP_MULT) || (w_op == OP_MULTU) || (w_op == OP_DIV) || (w_op == OP_DIVU);
  assign start   = w_is_md && !r_busy;
  assign busy    = r_busy;
  assign w_load  = ((w_op == OP_MULT) || (w_op == OP_MULTU)) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);

  assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign w_prod_u = {32'd0, A} * {32'd0, B};

  // A zero divisor or the MIN/-1 overflow is replaced by 1: the overflow case
  // then yields exactly LO=A, HI=0, and zero-divide results are never written.
  assign w_ovf    = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
  assign w_divu_b = (B == 32'd0) ? 32'd1 : B;
  assign w_sdiv_b = ((B == 32'd0) || w_ovf) ? 32'sd1 : $signed(B);
  assign w_sa     = $signed(A);
  assign w_quo_u  = A / w_divu_b;
  assign w_rem_u  = A % w_divu_b;
  assign w_quo_s  = w_sa / w_sdiv_b;
  assign w_rem_s  = w_sa % w_sdiv_b;

  // Result selection for the command being accepted.
  always_comb begin
    w_res_hi = 32'd0;
    w_res_lo = 32'd0;
    w_res_wr = 1'b1;
    case (w_op)
      OP_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
      OP_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
      OP_DIV: begin
        w_res_lo = w_quo_s;
        w_res_hi = w_rem_s;
        w_res_wr = (B != 32'd0);
      end
      OP_DIVU: begin
        w_res_lo = w_quo_u;
        w_res_hi = w_rem_u;
        w_res_wr = (B != 32'd0);
      end
      default: w_res_wr = 1'b0;
    endcase
  end

  // Move-from read port.
  always_comb begin
    HLOut = 32'd0;
    case (w_op)
      OP_MFHI: HLOut = HI;
      OP_MFLO: HLOut = LO;
      default: HLOut = 32'd0;
    endcase
  end

  // Latency counter and latched result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_res_wr <= 1'b0;
      r_res_hi <= 32'd0;
      r_res_lo <= 32'd0;
    end else if (start) begin
      r_cnt    <= w_load;
      r_busy   <= 1'b1;
      r_res_wr <= w_res_wr;
      r_res_hi <= w_res_hi;
      r_res_lo <= w_res_lo;
    end else if (r_cnt != '0) begin
      r_cnt    <= r_cnt - CW'(1);
      r_busy   <= (r_cnt != CW'(1));
    end
  end

  // HI/LO: commit on the final busy cycle, or direct move-to while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      HI <= 32'd0;
      LO <= 32'd0;
    end else if ((r_cnt == CW'(1)) && r_res_wr) begin
      HI <= r_res_hi;
      LO <= r_res_lo;
    end else if (!r_busy && (w_op == OP_MTHI)) begin
      HI <= A;
    end else if (!r_busy && (w_op == OP_MTLO)) begin
      LO <= A;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: hand-computed HI/LO results, busy timing,
// stall-while-busy behaviour and asynchronous reset mid-operation.
module tb_md_unit;

  logic        clk;
  logic        reset_n;
  logic [3:0]  HLOp;
  logic        en;
  logic [31:0] A;
  logic [31:0] B;
  logic        start;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] HLOut;

  int vectors;
  int miscompares;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .HLOp(HLOp), .en(en), .A(A), .B(B),
    .start(start), .busy(busy), .HI(HI), .LO(LO), .HLOut(HLOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    en = e; HLOp = op; A = a; B = b;
    #1;
  endtask

  // Issue one md command, expect start now, busy for n cycles with the old
  // HI/LO still visible, then the new HI/LO with busy low.
  task automatic run_md(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int n, input logic [31:0] old_hi, input logic [31:0] old_lo,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    drive(1'b1, op, a, b);
    check({tag, ".start"}, {31'd0, start}, 32'd1);
    next_cycle();
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    for (int i = 0; i < n; i++) begin
      check({tag, ".busy"}, {31'd0, busy}, 32'd1);
      check({tag, ".hi_pre"}, HI, old_hi);
      check({tag, ".lo_pre"}, LO, old_lo);
      next_cycle();
    end
    check({tag, ".busy_end"}, {31'd0, busy}, 32'd0);
    check({tag, ".hi"}, HI, exp_hi);
    check({tag, ".lo"}, LO, exp_lo);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset_n = 1'b0;
    en = 1'b0; HLOp = 4'd0; A = 32'd0; B = 32'd0;
    #1;
    next_cycle();
    next_cycle();
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.hi", HI, 32'd0);
    check("rst.lo", LO, 32'd0);
    check("rst.start", {31'd0, start}, 32'd0);
    check("rst.hlout", HLOut, 32'd0);
    reset_n = 1'b1;
    next_cycle();

    run_md("mult",  4'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_md("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFE);
    run_md("div",   4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'h0000_0001, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("divu",  4'd4, 32'd7, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1, 32'd3);

    // mthi and the move-from read port
    drive(1'b1, 4'd8, 32'h1234_5678, 32'd0);
    check("mthi.start", {31'd0, start}, 32'd0);
    check("mthi.hi_same", HI, 32'd1);
    next_cycle();
    check("mthi.hi", HI, 32'h1234_5678);
    check("mthi.lo", LO, 32'd3);
    check("mthi.busy", {31'd0, busy}, 32'd0);
    drive(1'b1, 4'd5, 32'd0, 32'd0);
    check("mflo.hlout", HLOut, 32'd3);
    drive(1'b1, 4'd6, 32'd0, 32'd0);
    check("mfhi.hlout", HLOut, 32'h1234_5678);
    drive(1'b0, 4'd6, 32'd0, 32'd0);
    check("mfhi_noen.hlout", HLOut, 32'd0);
    drive(1'b1, 4'd9, 32'd5, 32'd5);
    check("op9.start", {31'd0, start}, 32'd0);
    check("op9.hlout", HLOut, 32'd0);
    next_cycle();
    check("op9.busy", {31'd0, busy}, 32'd0);
    drive(1'b0, 4'd0, 32'd0, 32'd0);

    run_md("divu0", 4'd4, 32'd9, 32'd0, 10, 32'h1234_5678, 32'd3, 32'h1234_5678, 32'd3);
    run_md("div0",  4'd3, 32'd9, 32'd0, 10, 32'h1234_5678, 32'd3, 32'h1234_5678, 32'd3);
    run_md("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h1234_5678, 32'd3, 32'd0, 32'h8000_0000);

    // second mult held while busy
    drive(1'b1, 4'd1, 32'd3, 32'd5);
    check("b2b.start1", {31'd0, start}, 32'd1);
    next_cycle();
    drive(1'b1, 4'd1, 32'd7, 32'd6);
    for (int i = 0; i < 5; i++) begin
      check("b2b.stall", {31'd0, start}, 32'd0);
      check("b2b.busy", {31'd0, busy}, 32'd1);
      next_cycle();
    end
    check("b2b.busy_drop", {31'd0, busy}, 32'd0);
    check("b2b.lo1", LO, 32'd15);
    check("b2b.start2", {31'd0, start}, 32'd1);
    next_cycle();
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    for (int i = 0; i < 5; i++) next_cycle();
    check("b2b.busy2", {31'd0, busy}, 32'd0);
    check("b2b.hi2", HI, 32'd0);
    check("b2b.lo2", LO, 32'd42);

    // mtlo while busy is ignored
    drive(1'b1, 4'd1, 32'd2, 32'd2);
    check("mtlo_busy.start", {31'd0, start}, 32'd1);
    next_cycle();
    drive(1'b1, 4'd7, 32'h0000_DEAD, 32'd0);
    check("mtlo_busy.nostart", {31'd0, start}, 32'd0);
    next_cycle();
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    check("mtlo_busy.lo", LO, 32'd42);
    for (int i = 0; i < 4; i++) next_cycle();
    check("mtlo_busy.busy", {31'd0, busy}, 32'd0);
    check("mtlo_busy.lo_final", LO, 32'd4);

    // mtlo while idle, then reset in busy cycle 3 of a div
    drive(1'b1, 4'd7, 32'h0000_AAAA, 32'd0);
    next_cycle();
    check("mtlo.lo", LO, 32'h0000_AAAA);
    drive(1'b1, 4'd3, 32'd100, 32'd7);
    check("rstmid.start", {31'd0, start}, 32'd1);
    next_cycle();
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    next_cycle();
    next_cycle();
    check("rstmid.busy3", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("rstmid.busy", {31'd0, busy}, 32'd0);
    check("rstmid.hi", HI, 32'd0);
    check("rstmid.lo", LO, 32'd0);
    next_cycle();
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      check("rstmid.hi_after", HI, 32'd0);
      check("rstmid.lo_after", LO, 32'd0);
    end
    check("rstmid.busy_after", {31'd0, busy}, 32'd0);
    run_md("post_rst", 4'd4, 32'd7, 32'd2, 10, 32'd0, 32'd0, 32'd1, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
